// File: rtl/instr_queue_if.sv
// instr_queue_if: fetch2-side enqueue bundle and decode-side dequeue port of the
// instruction queue.
// Handshake: the fetch2 bundle (lanes flagged by in_pc_valid) is accepted in a
// cycle iff queue_full is low and no flush is active; queue_full comes straight
// from a register, so fetch2 may use it to squash without a combinational loop.
// Decode lane k transfers on a clock edge iff out_valid[k] && deq_ready[k];
// both vectors are thermometer coded (00/01/11).
interface instr_queue_if;
    logic [1:0]       in_pc_valid;
    logic [1:0][31:0] in_pc;
    logic [1:0][31:0] in_instr;
    logic [1:0]       in_is_ret;
    logic [1:0]       in_is_call;
    logic             in_bp_taken;
    logic [31:0]      in_bp_target;
    logic             queue_full;
    logic [1:0]       out_valid;
    logic [1:0][31:0] out_pc;
    logic [1:0][31:0] out_instr;
    logic [1:0]       out_is_ret;
    logic [1:0]       out_is_call;
    logic [1:0]       out_bp_taken;
    logic [1:0][31:0] out_bp_target;
    logic [1:0]       deq_ready;

    modport master (
        output in_pc_valid, in_pc, in_instr, in_is_ret, in_is_call,
               in_bp_taken, in_bp_target, deq_ready,
        input  queue_full, out_valid, out_pc, out_instr, out_is_ret,
               out_is_call, out_bp_taken, out_bp_target
    );

    modport slave (
        input  in_pc_valid, in_pc, in_instr, in_is_ret, in_is_call,
               in_bp_taken, in_bp_target, deq_ready,
        output queue_full, out_valid, out_pc, out_instr, out_is_ret,
               out_is_call, out_bp_taken, out_bp_target
    );
endinterface

// File: rtl/instr_queue.sv
// instr_queue: circular instruction buffer between fetch2 and decode.
// Takes up to two instructions per cycle, compacts them into the FIFO and
// presents the two oldest entries to decode. No same-cycle bypass.
// Optional macro IQ_PERF_CNT_EN adds saturating full/empty cycle counters;
// without it the perf ports are tied to zero.
module instr_queue #(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    instr_queue_if.slave iq,
    output logic [31:0]  perf_full_cycles,
    output logic [31:0]  perf_empty_cycles
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_TH  = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        is_ret;
        logic        is_call;
        logic        bp_taken;
        logic [31:0] bp_target;
    } entry_t;

    entry_t           ram_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0] head_p1, tail_p1;
    logic [PTR_W:0]   count_q, count_d;
    logic             queue_full_w;
    logic             enq_en;
    logic [1:0]       n_enq, n_deq;
    logic [1:0]       out_valid_w, deq_eff, deq_fire;
    entry_t           wr0, wr1, rd0, rd1;
    entry_t           lane0_plain, lane0_last, lane1_last;

    // Full leaves two free slots so a whole bundle always fits; register-only.
    assign queue_full_w = (count_q > FULL_TH);
    assign head_p1      = head_q + PTR_ONE;
    assign tail_p1      = tail_q + PTR_ONE;

    // Compact valid lanes in lane order; branch info rides on the last valid lane.
    always_comb begin
        enq_en      = !flush && !queue_full_w;
        lane0_plain = '{pc: iq.in_pc[0], instr: iq.in_instr[0], is_ret: iq.in_is_ret[0],
                        is_call: iq.in_is_call[0], bp_taken: 1'b0, bp_target: 32'h0};
        lane0_last  = lane0_plain;
        lane0_last.bp_taken  = iq.in_bp_taken;
        lane0_last.bp_target = iq.in_bp_target;
        lane1_last  = '{pc: iq.in_pc[1], instr: iq.in_instr[1], is_ret: iq.in_is_ret[1],
                        is_call: iq.in_is_call[1], bp_taken: iq.in_bp_taken,
                        bp_target: iq.in_bp_target};
        wr0   = lane0_plain;
        wr1   = lane1_last;
        n_enq = 2'd0;
        case (iq.in_pc_valid)
            2'b01: begin wr0 = lane0_last; n_enq = 2'd1; end
            2'b10: begin wr0 = lane1_last; n_enq = 2'd1; end
            2'b11: begin wr0 = lane0_plain; wr1 = lane1_last; n_enq = 2'd2; end
            default: n_enq = 2'd0;
        endcase
        if (!enq_en) n_enq = 2'd0;
    end

    // Decode view: thermometer valid, blanked during flush and when empty.
    always_comb begin
        out_valid_w = 2'b11;
        if (flush || count_q == '0) out_valid_w = 2'b00;
        else if (count_q == (PTR_W+1)'(1)) out_valid_w = 2'b01;
        deq_eff  = (iq.deq_ready == 2'b10) ? 2'b00 : iq.deq_ready;
        deq_fire = out_valid_w & deq_eff;
        n_deq    = {1'b0, deq_fire[0]} + {1'b0, deq_fire[1]};
        rd0      = out_valid_w[0] ? ram_q[head_q]  : '0;
        rd1      = out_valid_w[1] ? ram_q[head_p1] : '0;
    end

    // Pointer and occupancy next state; flush wins over enqueue and dequeue.
    always_comb begin
        head_d  = head_q + PTR_W'(n_deq);
        tail_d  = tail_q + PTR_W'(n_enq);
        count_d = count_q + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_deq);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (n_enq != 2'd0) ram_q[tail_q]  <= wr0;
        if (n_enq == 2'd2) ram_q[tail_p1] <= wr1;
    end

    assign iq.queue_full    = queue_full_w;
    assign iq.out_valid     = out_valid_w;
    assign iq.out_pc        = {rd1.pc, rd0.pc};
    assign iq.out_instr     = {rd1.instr, rd0.instr};
    assign iq.out_is_ret    = {rd1.is_ret, rd0.is_ret};
    assign iq.out_is_call   = {rd1.is_call, rd0.is_call};
    assign iq.out_bp_taken  = {rd1.bp_taken, rd0.bp_taken};
    assign iq.out_bp_target = {rd1.bp_target, rd0.bp_target};

`ifdef IQ_PERF_CNT_EN
    logic [31:0] perf_full_q, perf_empty_q;

    // Saturating stall/starve counters; survive flush, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_full_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            if (queue_full_w && iq.in_pc_valid != 2'b00 && !flush && perf_full_q != '1)
                perf_full_q <= perf_full_q + 32'd1;
            if (count_q == '0 && perf_empty_q != '1)
                perf_empty_q <= perf_empty_q + 32'd1;
        end
    end

    assign perf_full_cycles  = perf_full_q;
    assign perf_empty_cycles = perf_empty_q;
`else
    assign perf_full_cycles  = 32'h0;
    assign perf_empty_cycles = 32'h0;
`endif

    a_deq_ready_thermo: assert property (@(posedge clk) disable iff (!resetn)
        iq.deq_ready != 2'b10);
    a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
        count_q <= DEPTH_C);
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: scoreboard bench for instr_queue (DEPTH=16).
`timescale 1ns/1ps
module tb_instr_queue;
    localparam int DEPTH = 16;
    localparam int W     = 99;

    logic        clk    = 1'b0;
    logic        resetn = 1'b1;
    logic        flush  = 1'b0;
    logic [31:0] perf_full_cycles, perf_empty_cycles;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  m_perf_full  = 32'd0;
    logic [31:0]  m_perf_empty = 32'd0;

    instr_queue_if iq();

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .iq                (iq),
        .perf_full_cycles  (perf_full_cycles),
        .perf_empty_cycles (perf_empty_cycles)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [31:0] pc, input logic [31:0] ins,
                                        input logic rt, input logic cl, input logic tk,
                                        input logic [31:0] tgt);
        return {pc, ins, rt, cl, tk, tgt};
    endfunction

    function automatic logic [1:0] exp_ov();
        if (flush || exp_q.size() == 0) return 2'b00;
        if (exp_q.size() == 1) return 2'b01;
        return 2'b11;
    endfunction

    function automatic logic exp_full();
        return exp_q.size() > DEPTH - 2;
    endfunction

    function automatic logic [W-1:0] obs_lane(input int k);
        return {iq.out_pc[k], iq.out_instr[k], iq.out_is_ret[k], iq.out_is_call[k],
                iq.out_bp_taken[k], iq.out_bp_target[k]};
    endfunction

    // Driver
    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic tk, input logic [31:0] tgt, input logic [1:0] deq,
                         input logic fl);
        iq.in_pc_valid  = v;
        iq.in_pc[0]     = pc0;
        iq.in_pc[1]     = pc1;
        iq.in_instr[0]  = $urandom;
        iq.in_instr[1]  = $urandom;
        iq.in_is_ret    = 2'($urandom_range(0, 3));
        iq.in_is_call   = 2'($urandom_range(0, 3));
        iq.in_bp_taken  = tk;
        iq.in_bp_target = tgt;
        iq.deq_ready    = deq;
        flush           = fl;
    endtask

    // Scoreboard update for the coming clock edge (called after the cycle's checks)
    task automatic sb_commit();
        logic [1:0]   ov, fire;
        logic         acc;
        logic [W-1:0] l0n, l0b, l1b;
        ov   = exp_ov();
        acc  = !flush && !exp_full();
`ifdef IQ_PERF_CNT_EN
        if (exp_full() && iq.in_pc_valid != 2'b00 && !flush) m_perf_full = m_perf_full + 32'd1;
        if (exp_q.size() == 0) m_perf_empty = m_perf_empty + 32'd1;
`endif
        fire = ov & iq.deq_ready;
        if (fire[0]) void'(exp_q.pop_front());
        if (fire[1]) void'(exp_q.pop_front());
        l0n = mk(iq.in_pc[0], iq.in_instr[0], iq.in_is_ret[0], iq.in_is_call[0], 1'b0, 32'h0);
        l0b = mk(iq.in_pc[0], iq.in_instr[0], iq.in_is_ret[0], iq.in_is_call[0],
                 iq.in_bp_taken, iq.in_bp_target);
        l1b = mk(iq.in_pc[1], iq.in_instr[1], iq.in_is_ret[1], iq.in_is_call[1],
                 iq.in_bp_taken, iq.in_bp_target);
        if (flush) exp_q.delete();
        else if (acc) begin
            if (iq.in_pc_valid == 2'b01) exp_q.push_back(l0b);
            if (iq.in_pc_valid == 2'b10) exp_q.push_back(l1b);
            if (iq.in_pc_valid == 2'b11) begin
                exp_q.push_back(l0n);
                exp_q.push_back(l1b);
            end
        end
    endtask

    task automatic test_reset();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (iq.out_valid !== 2'b00) begin errors++; $display("FAIL reset out_valid: got %b expected 00", iq.out_valid); end
        checks++;
        if (iq.queue_full !== 1'b0) begin errors++; $display("FAIL reset queue_full: got %b expected 0", iq.queue_full); end
        checks++;
        if (iq.out_pc !== 64'h0 || iq.out_bp_target !== 64'h0 || iq.out_instr !== 64'h0)
            begin errors++; $display("FAIL reset out data: got pc %h tgt %h expected 0", iq.out_pc, iq.out_bp_target); end
        checks++;
        if (perf_full_cycles !== 32'd0 || perf_empty_cycles !== 32'd0)
            begin errors++; $display("FAIL reset perf: got %0d/%0d expected 0/0", perf_full_cycles, perf_empty_cycles); end
        exp_q.delete();
        m_perf_full  = 32'd0;
        m_perf_empty = 32'd0;
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        logic [1:0] ov;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(2'b11, 32'hBFC0_0000, 32'hBFC0_0004, 1'b0, 32'h0, 2'b00, 1'b0);
            else drive(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, (i == 2) ? 2'b11 : 2'b00, 1'b0);
            @(negedge clk);
            ov = exp_ov();
            checks++;
            if (iq.out_valid !== ov) begin errors++; $display("FAIL basic out_valid c%0d: got %b expected %b", i, iq.out_valid, ov); end
            for (int k = 0; k < 2; k++) if (ov[k]) begin
                checks++;
                if (obs_lane(k) !== exp_q[k]) begin errors++; $display("FAIL basic lane%0d c%0d: got %h expected %h", k, i, obs_lane(k), exp_q[k]); end
            end
            if (i == 1) begin
                checks++;
                if (iq.out_valid !== 2'b11 || iq.out_pc[0] !== 32'hBFC0_0000 || iq.out_pc[1] !== 32'hBFC0_0004)
                    begin errors++; $display("FAIL basic first bundle: got %b %h expected 11 bfc00004bfc00000", iq.out_valid, iq.out_pc); end
            end
            sb_commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_lane();
        logic [1:0] ov;
        logic [1:0] vt [6] = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00};
        logic [1:0] dt [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11};
        for (int i = 0; i < 6; i++) begin
            drive(vt[i], 32'h8000_0100 + 32'(8 * i), 32'h8000_0104 + 32'(8 * i), 1'b1, 32'h8000_0200, dt[i], 1'b0);
            @(negedge clk);
            ov = exp_ov();
            checks++;
            if (iq.out_valid !== ov) begin errors++; $display("FAIL single out_valid c%0d: got %b expected %b", i, iq.out_valid, ov); end
            for (int k = 0; k < 2; k++) if (ov[k]) begin
                checks++;
                if (obs_lane(k) !== exp_q[k]) begin errors++; $display("FAIL single lane%0d c%0d: got %h expected %h", k, i, obs_lane(k), exp_q[k]); end
            end
            if (i == 1) begin
                checks++;
                if (iq.out_valid !== 2'b01 || iq.out_pc[0] !== 32'h8000_0104 || iq.out_bp_taken[0] !== 1'b1
                    || iq.out_bp_target[0] !== 32'h8000_0200)
                    begin errors++; $display("FAIL single lane1-only: got v %b pc %h tk %b tgt %h expected 01 80000104 1 80000200",
                        iq.out_valid, iq.out_pc[0], iq.out_bp_taken[0], iq.out_bp_target[0]); end
            end
            sb_commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fill();
        logic [1:0] ov;
        for (int i = 0; i < 20; i++) begin
            drive((i < 10) ? 2'b11 : 2'b00, 32'h0000_1000 + 32'(8 * i), 32'h0000_1004 + 32'(8 * i),
                  1'($urandom_range(0, 1)), $urandom, (i == 10 || i >= 12) ? 2'b11 : 2'b00, 1'b0);
            @(negedge clk);
            ov = exp_ov();
            checks++;
            if (iq.out_valid !== ov) begin errors++; $display("FAIL fill out_valid c%0d: got %b expected %b", i, iq.out_valid, ov); end
            checks++;
            if (iq.queue_full !== exp_full()) begin errors++; $display("FAIL fill queue_full c%0d: got %b expected %b", i, iq.queue_full, exp_full()); end
            for (int k = 0; k < 2; k++) if (ov[k]) begin
                checks++;
                if (obs_lane(k) !== exp_q[k]) begin errors++; $display("FAIL fill lane%0d c%0d: got %h expected %h", k, i, obs_lane(k), exp_q[k]); end
            end
            if (i == 8 || i == 11) begin
                checks++;
                if (iq.queue_full !== (i == 8)) begin errors++; $display("FAIL fill full edge c%0d: got %b expected %b", i, iq.queue_full, (i == 8)); end
            end
            sb_commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ov;
        for (int i = 0; i < 23; i++) begin
            drive((i < 21) ? 2'b11 : 2'b00, 32'h9000_0000 + 32'(8 * i), 32'h9000_0004 + 32'(8 * i),
                  1'($urandom_range(0, 1)), $urandom, 2'b11, 1'b0);
            @(negedge clk);
            ov = exp_ov();
            checks++;
            if (iq.out_valid !== ov) begin errors++; $display("FAIL b2b out_valid c%0d: got %b expected %b", i, iq.out_valid, ov); end
            for (int k = 0; k < 2; k++) if (ov[k]) begin
                checks++;
                if (obs_lane(k) !== exp_q[k]) begin errors++; $display("FAIL b2b lane%0d c%0d: got %h expected %h", k, i, obs_lane(k), exp_q[k]); end
            end
            if (i >= 1 && i <= 21) begin
                checks++;
                if (iq.out_valid !== 2'b11 || iq.out_pc[0] !== 32'h9000_0000 + 32'(8 * (i - 1)))
                    begin errors++; $display("FAIL b2b order c%0d: got %b %h expected 11 %h", i, iq.out_valid, iq.out_pc[0], 32'h9000_0000 + 32'(8 * (i - 1))); end
            end
            sb_commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        logic [1:0] ov;
        logic [1:0] vt [9] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00, 2'b11, 2'b00};
        logic [1:0] dt [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 9; i++) begin
            drive(vt[i], 32'hA000_0000 + 32'(8 * i), 32'hA000_0004 + 32'(8 * i), 1'b1, $urandom, dt[i], (i == 5));
            @(negedge clk);
            ov = exp_ov();
            checks++;
            if (iq.out_valid !== ov) begin errors++; $display("FAIL flush out_valid c%0d: got %b expected %b", i, iq.out_valid, ov); end
            checks++;
            if (iq.queue_full !== exp_full()) begin errors++; $display("FAIL flush queue_full c%0d: got %b expected %b", i, iq.queue_full, exp_full()); end
            for (int k = 0; k < 2; k++) if (ov[k]) begin
                checks++;
                if (obs_lane(k) !== exp_q[k]) begin errors++; $display("FAIL flush lane%0d c%0d: got %h expected %h", k, i, obs_lane(k), exp_q[k]); end
            end
            if (i == 5 || i == 6) begin
                checks++;
                if (iq.out_valid !== 2'b00 || iq.queue_full !== 1'b0)
                    begin errors++; $display("FAIL flush cleared c%0d: got v %b full %b expected 00 0", i, iq.out_valid, iq.queue_full); end
            end
            sb_commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [1:0] ov, dq;
        for (int i = 0; i < 310; i++) begin
            case ($urandom_range(0, 2))
                0: dq = 2'b00;
                1: dq = 2'b01;
                default: dq = 2'b11;
            endcase
            if (i >= 300) drive(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 2'b11, 1'b0);
            else drive(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                       dq, ($urandom_range(0, 19) == 0));
            @(negedge clk);
            ov = exp_ov();
            checks++;
            if (iq.out_valid !== ov) begin errors++; $display("FAIL random out_valid c%0d: got %b expected %b", i, iq.out_valid, ov); end
            checks++;
            if (iq.queue_full !== exp_full()) begin errors++; $display("FAIL random queue_full c%0d: got %b expected %b", i, iq.queue_full, exp_full()); end
            for (int k = 0; k < 2; k++) if (ov[k]) begin
                checks++;
                if (obs_lane(k) !== exp_q[k]) begin errors++; $display("FAIL random lane%0d c%0d: got %h expected %h", k, i, obs_lane(k), exp_q[k]); end
            end
            checks++;
            if (perf_full_cycles !== m_perf_full || perf_empty_cycles !== m_perf_empty)
                begin errors++; $display("FAIL random perf c%0d: got %0d/%0d expected %0d/%0d", i, perf_full_cycles, perf_empty_cycles, m_perf_full, m_perf_empty); end
            sb_commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        logic [1:0] ov;
        for (int i = 0; i < 4; i++) begin
            drive((i < 3) ? 2'b11 : 2'b00, 32'hC000_0000 + 32'(8 * i), 32'hC000_0004 + 32'(8 * i), 1'b1, $urandom, 2'b00, 1'b0);
            @(negedge clk);
            ov = exp_ov();
            checks++;
            if (iq.out_valid !== ov) begin errors++; $display("FAIL midreset out_valid c%0d: got %b expected %b", i, iq.out_valid, ov); end
            sb_commit();
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (iq.out_valid !== 2'b00 || iq.queue_full !== 1'b0 || iq.out_pc !== 64'h0 || iq.out_bp_taken !== 2'b00)
            begin errors++; $display("FAIL midreset async clear: got v %b full %b pc %h expected 00 0 0", iq.out_valid, iq.queue_full, iq.out_pc); end
        exp_q.delete();
        m_perf_full  = 32'd0;
        m_perf_empty = 32'd0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_perf();
        logic [1:0] ov;
        for (int i = 0; i < 26; i++) begin
            drive((i >= 3 && i < 16) ? 2'b11 : 2'b00, 32'hD000_0000 + 32'(8 * i), 32'hD000_0004 + 32'(8 * i),
                  1'b0, 32'h0, (i >= 16) ? 2'b11 : 2'b00, 1'b0);
            @(negedge clk);
            ov = exp_ov();
            checks++;
            if (iq.out_valid !== ov) begin errors++; $display("FAIL perf out_valid c%0d: got %b expected %b", i, iq.out_valid, ov); end
            for (int k = 0; k < 2; k++) if (ov[k]) begin
                checks++;
                if (obs_lane(k) !== exp_q[k]) begin errors++; $display("FAIL perf lane%0d c%0d: got %h expected %h", k, i, obs_lane(k), exp_q[k]); end
            end
            checks++;
            if (perf_full_cycles !== m_perf_full || perf_empty_cycles !== m_perf_empty)
                begin errors++; $display("FAIL perf model c%0d: got %0d/%0d expected %0d/%0d", i, perf_full_cycles, perf_empty_cycles, m_perf_full, m_perf_empty); end
            if (i == 3) begin
                checks++;
`ifdef IQ_PERF_CNT_EN
                if (perf_empty_cycles < 32'd3) begin errors++; $display("FAIL perf empty after reset: got %0d expected >=3", perf_empty_cycles); end
`else
                if (perf_empty_cycles !== 32'd0) begin errors++; $display("FAIL perf empty tied: got %0d expected 0", perf_empty_cycles); end
`endif
            end
            if (i == 16) begin
                checks++;
`ifdef IQ_PERF_CNT_EN
                if (perf_full_cycles !== 32'd5) begin errors++; $display("FAIL perf full hold: got %0d expected 5", perf_full_cycles); end
`else
                if (perf_full_cycles !== 32'd0) begin errors++; $display("FAIL perf full tied: got %0d expected 0", perf_full_cycles); end
`endif
            end
            sb_commit();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_lane();
        test_fill();
        test_back_to_back();
        test_flush();
        test_random();
        test_mid_reset();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
